// File: rtl/aes_pkg.sv
// Shared constants, FSM encoding and GF(2^8) / S-box helpers for the AES-256 forward core.
package aes_pkg;

    localparam int NR    = 14;
    localparam int BLK_W = 128;

    // Round index of the final round, in the width of the round counter.
    localparam logic [3:0] NR_LAST = 4'd14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] base;
        // ~b equals 255-b, so this addresses the table from its top byte.
        base = {~b, 3'b000};
        return SBOX_TBL[base +: 8];
    endfunction

    // Multiply by x modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end else begin
                p = p;
            end
            aa = xtime(aa);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_enc_round_fun.sv
// One combinational AES encryption round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_enc_round_fun
    import aes_pkg::*;
(
    input  logic [127:0] inData,
    input  logic [127:0] inKey,
    input  logic         inLast,
    output logic [127:0] outData
);

    // Byte n of the state lives at bits [127-8n -: 8]; byte r+4c is row r, column c.
    logic [7:0] w_sb [16];
    logic [7:0] w_sr [16];
    logic [7:0] w_mc [16];

    // SubBytes through the constant table
    always_comb begin
        for (int n = 0; n < 16; n++) begin
            w_sb[n] = sbox(inData[127-8*n -: 8]);
        end
    end

    // ShiftRows: row r rotates left by r columns
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_sr[4*c+r] = w_sb[4*((c+r)%4)+r];
            end
        end
    end

    // MixColumns, bypassed in the final round
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            if (inLast) begin
                w_mc[4*c+0] = w_sr[4*c+0];
                w_mc[4*c+1] = w_sr[4*c+1];
                w_mc[4*c+2] = w_sr[4*c+2];
                w_mc[4*c+3] = w_sr[4*c+3];
            end else begin
                w_mc[4*c+0] = gf_mul(w_sr[4*c+0], 8'h02) ^ gf_mul(w_sr[4*c+1], 8'h03) ^ w_sr[4*c+2] ^ w_sr[4*c+3];
                w_mc[4*c+1] = w_sr[4*c+0] ^ gf_mul(w_sr[4*c+1], 8'h02) ^ gf_mul(w_sr[4*c+2], 8'h03) ^ w_sr[4*c+3];
                w_mc[4*c+2] = w_sr[4*c+0] ^ w_sr[4*c+1] ^ gf_mul(w_sr[4*c+2], 8'h02) ^ gf_mul(w_sr[4*c+3], 8'h03);
                w_mc[4*c+3] = gf_mul(w_sr[4*c+0], 8'h03) ^ w_sr[4*c+1] ^ w_sr[4*c+2] ^ gf_mul(w_sr[4*c+3], 8'h02);
            end
        end
    end

    // AddRoundKey and repack into the 128-bit bus
    always_comb begin
        outData = 128'd0;
        for (int n = 0; n < 16; n++) begin
            outData[127-8*n -: 8] = w_mc[n] ^ inKey[127-8*n -: 8];
        end
    end

endmodule

// File: rtl/aes_enc_round_iter.sv
// Iterative AES-256 encryption core: one round per clock, round keys fetched from an external store.
module aes_enc_round_iter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rstN,
    input  logic         inValid,
    output logic         inReady,
    input  logic [127:0] inData,
    output logic [3:0]   outRkIdx,
    input  logic [127:0] inRoundKey,
    output logic         outValid,
    input  logic         outReady,
    output logic [127:0] outData
);

    state_t       r_state;
    logic [3:0]   r_rnd;
    logic [127:0] r_st;
    logic         r_valid;
    logic [3:0]   r_rk_idx;

    logic         w_last;
    logic [127:0] w_round;

    assign w_last = (r_rnd == NR_LAST);

    aes_enc_round_fun u_round (
        .inData  (r_st),
        .inKey   (inRoundKey),
        .inLast  (w_last),
        .outData (w_round)
    );

    // FSM, round counter, state register and the registered valid / key-index outputs
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_state  <= IDLE;
            r_rnd    <= 4'd0;
            r_st     <= 128'd0;
            r_valid  <= 1'b0;
            r_rk_idx <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (inValid) begin
                        r_st     <= inData ^ inRoundKey;
                        r_rnd    <= 4'd1;
                        r_rk_idx <= 4'd1;
                        r_state  <= RUN;
                    end else begin
                        r_state  <= IDLE;
                    end
                end
                RUN: begin
                    r_st  <= w_round;
                    r_rnd <= r_rnd + 4'd1;
                    if (w_last) begin
                        r_state  <= DONE;
                        r_valid  <= 1'b1;
                        r_rk_idx <= 4'd0;
                    end else begin
                        r_rk_idx <= r_rnd + 4'd1;
                    end
                end
                DONE: begin
                    if (outReady) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                    end else begin
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_valid  <= 1'b0;
                    r_rk_idx <= 4'd0;
                end
            endcase
        end
    end

    // Ready must drop in the very cycle reset is asserted, so it also looks at rstN.
    assign inReady  = rstN && (r_state == IDLE);
    assign outValid = r_valid;
    assign outRkIdx = r_rk_idx;
    assign outData  = r_st;

endmodule

// File: tb/tb_aes_enc_round_iter.sv
// Scoreboard bench for aes_enc_round_iter with an AES-256 key-expansion key store.
module tb_aes_enc_round_iter;

    logic         clk;
    logic         rstN;
    logic         inValid;
    logic         inReady;
    logic [127:0] inData;
    logic [3:0]   outRkIdx;
    logic [127:0] inRoundKey;
    logic         outValid;
    logic         outReady;
    logic [127:0] outData;

    aes_enc_round_iter dut (
        .clk        (clk),
        .rstN       (rstN),
        .inValid    (inValid),
        .inReady    (inReady),
        .inData     (inData),
        .outRkIdx   (outRkIdx),
        .inRoundKey (inRoundKey),
        .outValid   (outValid),
        .outReady   (outReady),
        .outData    (outData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    localparam logic [2047:0] TB_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] tb_sb(input logic [7:0] b);
        int idx;
        idx = 2047 - 8 * int'(b);
        return TB_SBOX[idx -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {tb_sb(w[31:24]), tb_sb(w[23:16]), tb_sb(w[15:8]), tb_sb(w[7:0])};
    endfunction

    // Key store: round keys 0..14, entry 15 unused.
    logic [127:0] rk [16];

    always_comb begin
        inRoundKey = rk[outRkIdx];
    end

    task automatic set_key(input logic [255:0] k);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (i % 8 == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        rk[15] = 128'd0;
    endtask

    // Scoreboard state
    logic [127:0] exp_q [$];
    int           acc_q [$];
    logic [127:0] cur_exp;
    int           cyc = 0;
    bit           post_hs = 1'b0;
    bit           post_rst = 1'b0;
    logic         prev_valid = 1'b0;

    // Monitor: samples at the falling edge, between input drive and the next active edge
    always @(negedge clk) begin
        cyc++;
        if (post_rst) begin
            chk("rst_valid", {127'd0, outValid}, 128'd0);
            chk("rst_data", outData, 128'd0);
            chk("rst_rkidx", {124'd0, outRkIdx}, 128'd0);
            chk("rst_ready", {127'd0, inReady}, {127'd0, rstN});
            post_rst = 1'b0;
        end
        if (!rstN) begin
            chk("ready_in_reset", {127'd0, inReady}, 128'd0);
            exp_q.delete();
            acc_q.delete();
            post_rst = 1'b1;
            post_hs  = 1'b0;
        end else begin
            if (post_hs) begin
                chk("idle_after_hs", {126'd0, inReady, outValid}, {126'd0, 1'b1, 1'b0});
                post_hs = 1'b0;
            end
            if (acc_q.size() > 0 && !outValid) begin
                chk("rkidx_run", {124'd0, outRkIdx}, 128'(cyc - acc_q[0]));
                chk("ready_busy", {127'd0, inReady}, 128'd0);
            end
            if (outValid && !prev_valid) begin
                if (acc_q.size() > 0) chk("latency", 128'(cyc - acc_q[0]), 128'd15);
                else chk("spurious_valid", {127'd0, outValid}, 128'd0);
            end
            if (outValid && exp_q.size() > 0) begin
                chk("out_data", outData, exp_q[0]);
                if (outReady) begin
                    void'(exp_q.pop_front());
                    void'(acc_q.pop_front());
                    post_hs = 1'b1;
                end
            end
            if (inValid && inReady) begin
                chk("rkidx_idle", {124'd0, outRkIdx}, 128'd0);
                exp_q.push_back(cur_exp);
                acc_q.push_back(cyc);
            end
        end
        prev_valid = outValid;
    end

    task automatic send(input logic [127:0] pt, input logic [127:0] ex, input bit keep, output int waited);
        inValid = 1'b1;
        inData  = pt;
        cur_exp = ex;
        waited  = 0;
        while (!(inReady && rstN) && waited < 100) begin
            @(posedge clk); #2;
            waited++;
        end
        chk("accept_seen", {127'd0, inReady && rstN}, 128'd1);
        @(posedge clk); #2;
        waited++;
        if (!keep) inValid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && inReady) && n < 300) begin
            @(posedge clk); #2;
            n++;
        end
        chk("drain", {127'd0, exp_q.size() == 0 && inReady}, 128'd1);
    endtask

    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_SP = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] PT_C3  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] CT_Z   = 128'hdc95c078a2408989ad48a21492842087;

    logic [127:0] sp_pt [4] = '{128'h6bc1bee22e409f96e93d7e117393172a, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
                                128'h30c81c46a35ce411e5fbc1191a0a52ef, 128'hf69f2445df4f9b17ad2b417be66c3710};
    logic [127:0] sp_ct [4] = '{128'hf3eed1bdb5d2a03c064b5a7e3db181f8, 128'h591ccb10d410ed26dc5ba74a31362870,
                                128'hb6ed21b99ca6f4f9f153e7b1beafed1d, 128'h23304b7a39f9f3ff067d8d8f9e24ecc7};

    initial begin
        int w;
        int n;
        rstN     = 1'b0;
        inValid  = 1'b1;
        inData   = PT_C3;
        cur_exp  = CT_C3;
        outReady = 1'b1;
        set_key(KEY_C3);
        // Reset with inValid high: reset must win
        repeat (3) @(posedge clk);
        #2;
        rstN    = 1'b1;
        inValid = 1'b0;
        @(posedge clk); #2;

        // FIPS-197 C.3
        send(PT_C3, CT_C3, 1'b0, w);
        wait_done();

        // All-zero key and plaintext
        set_key(256'd0);
        send(128'd0, CT_Z, 1'b0, w);
        wait_done();

        // Back-pressure: hold outReady low for 5 cycles once outValid rises
        set_key(KEY_SP);
        outReady = 1'b0;
        send(sp_pt[0], sp_ct[0], 1'b0, w);
        n = 0;
        while (!outValid && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        chk("bp_valid_seen", {127'd0, outValid}, 128'd1);
        repeat (5) @(posedge clk);
        #2;
        outReady = 1'b1;
        wait_done();

        // Back-to-back with inValid held, then junk pulses during RUN
        send(sp_pt[1], sp_ct[1], 1'b1, w);
        send(sp_pt[2], sp_ct[2], 1'b1, w);
        chk("b2b_gap", 128'(w), 128'd16);
        for (int i = 0; i < 8; i++) begin
            inValid = i[0];
            inData  = {$urandom(), $urandom(), $urandom(), $urandom()};
            cur_exp = 128'd0;
            @(posedge clk); #2;
        end
        inValid = 1'b0;
        wait_done();

        // Reset at round 7; the block in flight must vanish
        set_key(KEY_C3);
        send(PT_C3, CT_C3, 1'b0, w);
        n = 0;
        while (outRkIdx != 4'd7 && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        chk("round7_seen", {124'd0, outRkIdx}, 128'd7);
        rstN = 1'b0;
        @(posedge clk); #2;
        rstN = 1'b1;
        repeat (25) @(posedge clk);
        #2;
        send(PT_C3, CT_C3, 1'b0, w);
        wait_done();

        // One more vector under the second key
        set_key(KEY_SP);
        send(sp_pt[3], sp_ct[3], 1'b0, w);
        wait_done();

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
